experiment1: RTL and testbench
==============================

Name: experiment1

Overview:
- Switch-driven exerciser for one on-chip 256x8 synchronous RAM on the board top level.
- Switches supply the address, the write data and a write strobe.
- Read data goes to green LEDs; address, write data and read data appear as hex on the seven-segment displays.
- Red LEDs mirror the registered switch bank.

Parameters:
- none (memory is fixed at 256 words x 8 bits).

Ports:
- CLOCK_50_I  input  1  system clock; all state updates on its rising edge.
- RESET_I  input  1  synchronous, active-high reset.
- SWITCH_I  input  18  [7:0] address, [15:8] write data, [16] spare (LED only), [17] write strobe.
- SEVEN_SEGMENT_N_O  output  7 x 8  unpacked array [7:0] of 7-bit active-low segment vectors; bit0=a ... bit6=g.
- LED_RED_O  output  18  registered copy of SWITCH_I.
- LED_GREEN_O  output  9  [7:0] RAM read data, [8] busy flag.

Behaviour:
- Reset and clock: one clock (CLOCK_50_I); RESET_I is synchronous and active-high.
- Switch register: sw_q <= SWITCH_I every cycle; reset value 0.
- Red LEDs: LED_RED_O = sw_q, so a switch change appears on the LEDs 1 cycle later.
- Write-strobe edge detect:
  - sw17_d <= sw_q[17]; reset value 0.
  - we = sw_q[17] & ~sw17_d, a single-cycle pulse per 0->1 transition.
  - Holding SWITCH_I[17] high produces no further writes; 1->0 transitions do nothing.
- Write: on the cycle we=1, mem[sw_q[7:0]] <= sw_q[15:8].
- Read:
  - rdata <= mem[sw_q[7:0]] every cycle; reset value 0x00.
  - Total latency from address switch change to LED_GREEN_O[7:0] is 2 cycles.
- Read-during-write to the same address is read-first: rdata gets the old word; the new word appears the following cycle.
- Memory power-up contents: mem[i] = i[7:0].
- Reset does not alter memory contents, except as described under Optional Feature.
- LED_GREEN_O[7:0] = rdata.
- LED_GREEN_O[8] = busy; constant 0 unless the optional feature is compiled in.
- Seven-segment digits, all combinational from registers:
  - [7] = sw_q[7:4], [6] = sw_q[3:0] (address).
  - [5] = sw_q[15:12], [4] = sw_q[11:8] (write data).
  - [3] = rdata[7:4], [2] = rdata[3:0] (read data).
  - [1] and [0] are blank, 7'h7F.
- Hex encoding {g..a}, active low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Values after reset:
  - LED_RED_O = 0, LED_GREEN_O = 0.
  - Digits [7:2] show "0", i.e. 7'b1000000.
- Address wrap: none needed; the address is exactly 8 bits.

Optional Feature:
- Macro: EXPERIMENT1_MEM_CLEAR_EN.
- Defined:
  - Reset arms a clear sequencer with states IDLE and CLEAR.
  - On the first cycle after RESET_I deasserts, it enters CLEAR and writes 0x00 to addresses 0..255, one per cycle.
  - busy=1 for exactly 256 cycles, then the sequencer returns to IDLE with busy=0.
  - Switch writes are ignored while busy; a strobe edge during CLEAR is discarded, not queued.
  - Reset asserted mid-clear restarts the sweep from address 0.
  - rdata follows normal reads throughout.
- Not defined:
  - No sequencer; busy is tied to 0.
  - Memory keeps its power-up or previously written contents across reset.

Test Plan:
- Reset, then SWITCH_I=18'h00000 -> 18'h00001 -> 18'h00003 -> 18'h00007, 100 ns apart:
  - LED_RED_O follows 0x00001, 0x00003, 0x00007 one cycle after each change.
  - LED_GREEN_O[7:0] = 0x01, 0x03, 0x07 two cycles after each change.
- SWITCH_I=18'h0A503, then set bit17 (18'h2A503):
  - One write, mem[0x03]=0xA5.
  - LED_GREEN_O[7:0]=0xA5 within 2 cycles.
  - Digits [3:2] show "A","5".
- Keep bit17 high and change data to 0x5A (18'h25A03): mem[0x03] stays 0xA5, no write.
- Strobe on addr 0x10 while the address is static: first read returns the old 0x10, next cycle returns the new data (read-first check).
- Pulse RESET_I mid-test without the macro: LEDs and rdata go to 0, and mem[0x03] still reads 0xA5 afterwards.
- With EXPERIMENT1_MEM_CLEAR_EN:
  - After reset, LED_GREEN_O[8]=1 for 256 cycles.
  - A strobe during this window is ignored.
  - Afterwards, reading addresses 0x00, 0x03 and 0xFF returns 0x00.

Source files
------------

// File: rtl/experiment1.sv
// -----------------------------------------------------------------------------
// experiment1 -- switch-driven exerciser for one on-chip 256x8 synchronous RAM.
//
// Switches supply address, write data and a write strobe. The strobe's rising
// edge performs one write. Read data is registered, shown on the green LEDs,
// and address / write data / read data are shown as hex digits.
//
// Ports:
//   CLOCK_50_I         in   1     system clock, rising edge
//   RESET_I            in   1     synchronous, active-high reset
//   SWITCH_I           in   18    [7:0] addr, [15:8] wdata, [16] spare, [17] strobe
//   SEVEN_SEGMENT_N_O  out  7x8   active-low segments {g..a}; [7:6] addr,
//                                 [5:4] wdata, [3:2] rdata, [1:0] blank
//   LED_RED_O          out  18    registered switch bank
//   LED_GREEN_O        out  9     [7:0] read data, [8] busy
//
// Optional macro EXPERIMENT1_MEM_CLEAR_EN: after every reset a sequencer
// writes 0x00 to all 256 addresses (busy=1 for 256 cycles); switch writes
// are dropped while it runs. Without it busy is tied to 0.
// -----------------------------------------------------------------------------
module experiment1 (
  input  logic        CLOCK_50_I,
  input  logic        RESET_I,
  input  logic [17:0] SWITCH_I,
  output logic [6:0]  SEVEN_SEGMENT_N_O [7:0],
  output logic [17:0] LED_RED_O,
  output logic [8:0]  LED_GREEN_O
);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic [17:0] sw_q, sw_d;
  logic        sw17_dly_q, sw17_dly_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        we;
  logic        busy;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_addr;
  logic [7:0]  mem_wr_data;

  // Each word is stored XORed with its own address, so the all-zero power-up
  // state of the array reads back as mem[i] = i without any init file.
  logic [7:0]  mem_q [256];

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    sw_d       = SWITCH_I;
    sw17_dly_d = sw_q[17];
    we         = sw_q[17] & ~sw17_dly_q;
    // Read-first: the old word is captured even when a write hits this address.
    rdata_d    = mem_q[sw_q[7:0]] ^ sw_q[7:0];
  end

`ifdef EXPERIMENT1_MEM_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} clr_state_e;

  clr_state_e state_q;
  logic       armed_q;
  logic       busy_q;
  logic [7:0] clr_addr_q;

  // Reset only arms the sweep; it starts on the first cycle out of reset.
  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      state_q    <= IDLE;
      armed_q    <= 1'b1;
      busy_q     <= 1'b0;
      clr_addr_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_q    <= CLEAR;
            armed_q    <= 1'b0;
            busy_q     <= 1'b1;
            clr_addr_q <= 8'h00;
          end
        end
        CLEAR: begin
          clr_addr_q <= clr_addr_q + 8'd1;
          if (clr_addr_q == 8'hFF) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = busy_q;
    mem_wr_en   = 1'b0;
    mem_wr_addr = sw_q[7:0];
    mem_wr_data = sw_q[15:8];
    if (!RESET_I) begin
      if (busy_q) begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = clr_addr_q;
        mem_wr_data = 8'h00;
      end else begin
        mem_wr_en   = we;
      end
    end
  end
`else
  always_comb begin
    busy        = 1'b0;
    mem_wr_en   = we & ~RESET_I;
    mem_wr_addr = sw_q[7:0];
    mem_wr_data = sw_q[15:8];
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      sw_q       <= '0;
      sw17_dly_q <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      sw_q       <= sw_d;
      sw17_dly_q <= sw17_dly_d;
      rdata_q    <= rdata_d;
    end
  end

  // NOTE: the RAM array has no reset; contents survive RESET_I and the
  // array maps onto block RAM.
  always_ff @(posedge CLOCK_50_I) begin
    if (mem_wr_en) begin
      mem_q[mem_wr_addr] <= mem_wr_data ^ mem_wr_addr;
    end
  end

  always_comb begin
    SEVEN_SEGMENT_N_O[7] = hex_to_seg(sw_q[7:4]);
    SEVEN_SEGMENT_N_O[6] = hex_to_seg(sw_q[3:0]);
    SEVEN_SEGMENT_N_O[5] = hex_to_seg(sw_q[15:12]);
    SEVEN_SEGMENT_N_O[4] = hex_to_seg(sw_q[11:8]);
    SEVEN_SEGMENT_N_O[3] = hex_to_seg(rdata_q[7:4]);
    SEVEN_SEGMENT_N_O[2] = hex_to_seg(rdata_q[3:0]);
    SEVEN_SEGMENT_N_O[1] = 7'h7F;
    SEVEN_SEGMENT_N_O[0] = 7'h7F;
  end

  assign LED_RED_O   = sw_q;
  assign LED_GREEN_O = {busy, rdata_q};

endmodule

// File: tb/tb_experiment1.sv
// -----------------------------------------------------------------------------
// tb_experiment1 -- scoreboard bench for experiment1.
// The driver applies switch/reset values on the falling edge, advances a
// behavioural model of the board (a plain memory array plus the visible
// registers) and queues the outputs expected after the next rising edge.
// A monitor pops one entry per rising edge and compares LEDs and digits.
// Define EXPERIMENT1_MEM_CLEAR_EN for both bench and RTL to cover the sweep.
// -----------------------------------------------------------------------------
module tb_experiment1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] sw  = '0;
  logic [6:0]  seg [7:0];
  logic [17:0] led_r;
  logic [8:0]  led_g;

  always #10 clk = ~clk;

  experiment1 dut (
    .CLOCK_50_I        (clk),
    .RESET_I           (rst),
    .SWITCH_I          (sw),
    .SEVEN_SEGMENT_N_O (seg),
    .LED_RED_O         (led_r),
    .LED_GREEN_O       (led_g)
  );

  typedef struct packed {
    logic [17:0] red;
    logic [8:0]  green;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Board model: memory contents, what the red LEDs show, the strobe level
  // seen last cycle, and what the green LEDs show.
  logic [7:0]  ref_mem [256];
  logic [17:0] ref_sw   = '0;
  logic        ref_prev = 1'b0;
  logic [7:0]  ref_rd   = '0;
  logic        ref_busy = 1'b0;
`ifdef EXPERIMENT1_MEM_CLEAR_EN
  logic        ref_armed = 1'b0;
  int          ref_clr   = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge with inputs (r, s) applied.
  task automatic model_edge(input logic r, input logic [17:0] s);
    logic [7:0] rd_new;
    logic       busy_before;
    exp_t       e;
    if (r) begin
      ref_sw   = '0;
      ref_prev = 1'b0;
      ref_rd   = 8'h00;
      ref_busy = 1'b0;
`ifdef EXPERIMENT1_MEM_CLEAR_EN
      ref_armed = 1'b1;
      ref_clr   = 0;
`endif
    end else begin
      rd_new      = ref_mem[ref_sw[7:0]];
      busy_before = ref_busy;
`ifdef EXPERIMENT1_MEM_CLEAR_EN
      if (ref_armed) begin
        ref_armed = 1'b0;
        ref_busy  = 1'b1;
        ref_clr   = 0;
      end else if (ref_busy) begin
        ref_mem[ref_clr] = 8'h00;
        ref_clr++;
        if (ref_clr == 256) ref_busy = 1'b0;
      end
`endif
      if (ref_sw[17] && !ref_prev && !busy_before)
        ref_mem[ref_sw[7:0]] = ref_sw[15:8];
      ref_prev = ref_sw[17];
      ref_sw   = s;
      ref_rd   = rd_new;
    end
    e.red   = ref_sw;
    e.green = {ref_busy, ref_rd};
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic r, input logic [17:0] s);
    @(negedge clk);
    rst = r;
    sw  = s;
    model_edge(r, s);
  endtask

  task automatic hold(input logic r, input logic [17:0] s, input int n);
    for (int i = 0; i < n; i++) cycle(r, s);
  endtask

  // Monitor: every rising edge presents a new output set.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led_red", 32'(led_r), 32'(e.red));
      check("led_green", 32'(led_g), 32'(e.green));
      check("seg7", 32'(seg[7]), 32'(seg_tbl[e.red[7:4]]));
      check("seg6", 32'(seg[6]), 32'(seg_tbl[e.red[3:0]]));
      check("seg5", 32'(seg[5]), 32'(seg_tbl[e.red[15:12]]));
      check("seg4", 32'(seg[4]), 32'(seg_tbl[e.red[11:8]]));
      check("seg3", 32'(seg[3]), 32'(seg_tbl[e.green[7:4]]));
      check("seg2", 32'(seg[2]), 32'(seg_tbl[e.green[3:0]]));
      check("seg1", 32'(seg[1]), 32'h7F);
      check("seg0", 32'(seg[0]), 32'h7F);
    end
  end

  initial begin
    logic [17:0] s;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);

    hold(1'b1, 18'h00000, 3);

`ifdef EXPERIMENT1_MEM_CLEAR_EN
    // Strobe inside the clear window is dropped; the sweep zeroes everything.
    hold(1'b0, 18'h0A503, 20);
    hold(1'b0, 18'h2A503, 10);
    hold(1'b0, 18'h00000, 240);
    hold(1'b0, 18'h00000, 3);
    hold(1'b0, 18'h00003, 3);
    hold(1'b0, 18'h000FF, 3);
`endif

    // Address walk, 100 ns (5 cycles) per step.
    hold(1'b0, 18'h00000, 5);
    hold(1'b0, 18'h00001, 5);
    hold(1'b0, 18'h00003, 5);
    hold(1'b0, 18'h00007, 5);

    // Single write on strobe edge, then held strobe with new data: no write.
    hold(1'b0, 18'h0A503, 3);
    hold(1'b0, 18'h2A503, 4);
    hold(1'b0, 18'h25A03, 4);
    hold(1'b0, 18'h05A03, 3);

    // Read-first on a static address.
    hold(1'b0, 18'h0C310, 3);
    hold(1'b0, 18'h2C310, 3);
    hold(1'b0, 18'h0C310, 3);

    // Reset pulse mid-test; memory persists (or is swept, with the macro).
    hold(1'b1, 18'h00003, 2);
    hold(1'b0, 18'h00003, 4);
`ifdef EXPERIMENT1_MEM_CLEAR_EN
    hold(1'b0, 18'h00003, 256);
`endif

    // Randomised traffic over a small address window to force reuse.
    s = 18'h00000;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) s[7:0] = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) s[15:8] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) s[17] = ~s[17];
      s[16] = 1'($urandom);
      cycle(($urandom_range(0, 299) == 0), s);
    end

    hold(1'b0, 18'h00000, 3);
    @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
